// File: rtl/cu_arbiter.sv
// ---------------------------------------------------------------------------
// accel_pkg / cu_arbiter
//
// Purpose: shares a single compute unit between four requesters. Only one
// job is in flight at a time. A round-robin grant picks the next job in
// IDLE. The job is issued to the compute unit and its completion (or a
// timeout) is awaited. The result is then returned to the granted
// requester.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   req_valid/ready    per-requester job handshake (ready is a one-hot pulse)
//   req_comp_type/data per-requester operation and operand
//   rsp_valid/ready    per-requester result handshake (valid is one-hot)
//   rsp_data, rsp_err  result payload; rsp_err=1 marks a timeout abort
//   cu_*               interface to the shared compute unit
//   busy               high whenever a job is in progress
//   timeout_cnt        saturating count of timeout aborts
// ---------------------------------------------------------------------------
package accel_pkg;
    typedef logic [31:0] data_t;
    typedef enum logic [1:0] {
        COMP_ADD = 2'd0,
        COMP_SUB = 2'd1,
        COMP_MUL = 2'd2,
        COMP_XOR = 2'd3
    } comp_type_e;
endpackage

module cu_arbiter
    import accel_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int N_REQ       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  comp_type_e       req_comp_type [N_REQ],
    input  data_t            req_data      [N_REQ],
    output logic [N_REQ-1:0] rsp_valid,
    input  logic [N_REQ-1:0] rsp_ready,
    output data_t            rsp_data,
    output logic             rsp_err,
    output logic [1:0]       cu_unit_id,
    output logic             cu_request,
    input  logic             cu_ready,
    input  logic             cu_done,
    output comp_type_e       cu_comp_type,
    output data_t            cu_data_in,
    input  data_t            cu_result,
    output logic             busy,
    output logic [15:0]      timeout_cnt
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e           state_reg, state_next;
    logic [1:0]       last_grant_reg;
    logic [1:0]       id_reg;
    comp_type_e       comp_reg;
    data_t            data_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    data_t            rsp_data_reg;
    logic             rsp_err_reg;
    logic [15:0]      timeout_cnt_reg;

    logic [1:0]       winner;
    logic             grant_fire;
    logic             issue_fire;
    logic             done_fire;
    logic             timeout_fire;
    logic             rsp_fire;

    // Round-robin search starting at last_grant+1. Walking the offsets from
    // farthest to nearest lets the nearest requesting candidate overwrite the
    // others, so no early exit is needed.
    always_comb begin
        logic [1:0] cand;
        winner = last_grant_reg;
        cand   = last_grant_reg;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = last_grant_reg + 2'(i);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

    // While reset is held no job can be accepted, so the accept pulse is
    // suppressed rather than advertising a grant that the state register
    // will discard.
    assign grant_fire   = rst_n && (state_reg == S_IDLE) && (|req_valid);
    assign issue_fire   = (state_reg == S_ISSUE) && cu_ready;
    assign done_fire    = (state_reg == S_WAIT) && cu_done;
    // Completion on the last counted cycle takes precedence over the timeout.
    assign timeout_fire = (state_reg == S_WAIT) && !cu_done && (wait_cnt_reg == CNT_LAST);
    assign rsp_fire     = (state_reg == S_RESP) && rsp_ready[id_reg];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (|req_valid)                 state_next = S_ISSUE;
            S_ISSUE: if (cu_ready)                   state_next = S_WAIT;
            S_WAIT:  if (cu_done || timeout_fire)    state_next = S_RESP;
            S_RESP:  if (rsp_ready[id_reg])          state_next = S_IDLE;
            default:                                 state_next = S_IDLE;
        endcase
    end

    // Job latches, wait counter, response registers and statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_reg  <= 2'd3;
            id_reg          <= 2'd0;
            comp_reg        <= COMP_ADD;
            data_reg        <= '0;
            wait_cnt_reg    <= '0;
            rsp_data_reg    <= '0;
            rsp_err_reg     <= 1'b0;
            timeout_cnt_reg <= '0;
        end else begin
            if (grant_fire) begin
                id_reg   <= winner;
                comp_reg <= req_comp_type[winner];
                data_reg <= req_data[winner];
            end

            if (issue_fire) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end

            if (done_fire) begin
                rsp_data_reg <= cu_result;
                rsp_err_reg  <= 1'b0;
            end else if (timeout_fire) begin
                // rsp_data keeps its previous value; the error flag marks it invalid
                rsp_err_reg <= 1'b1;
                if (timeout_cnt_reg != 16'hFFFF) begin
                    timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                end
            end

            if (rsp_fire) begin
                last_grant_reg <= id_reg;
            end
        end
    end

    // Per-requester handshake outputs
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
            assign req_ready[gi] = grant_fire && (winner == 2'(gi));
            assign rsp_valid[gi] = (state_reg == S_RESP) && (id_reg == 2'(gi));
        end
    endgenerate

    assign cu_request   = (state_reg == S_ISSUE);
    assign cu_unit_id   = id_reg;
    assign cu_comp_type = comp_reg;
    assign cu_data_in   = data_reg;
    assign rsp_data     = rsp_data_reg;
    assign rsp_err      = rsp_err_reg;
    assign busy         = (state_reg != S_IDLE);
    assign timeout_cnt  = timeout_cnt_reg;

endmodule

// File: tb/tb_cu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cu_arbiter
//
// Directed bench for cu_arbiter (TIMEOUT_CYC=8). The bench plays the role of
// the compute unit by driving cu_ready, cu_done and cu_result by hand.
// Inputs change 2 time units after the rising edge. Outputs are checked
// 1 time unit after that, well before the next edge.
// ---------------------------------------------------------------------------
module tb_cu_arbiter;
    import accel_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    comp_type_e req_comp_type [4];
    data_t      req_data      [4];
    logic [3:0] rsp_valid;
    logic [3:0] rsp_ready;
    data_t      rsp_data;
    logic       rsp_err;
    logic [1:0] cu_unit_id;
    logic       cu_request;
    logic       cu_ready;
    logic       cu_done;
    comp_type_e cu_comp_type;
    data_t      cu_data_in;
    data_t      cu_result;
    logic       busy;
    logic [15:0] timeout_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cu_arbiter #(.TIMEOUT_CYC(8), .N_REQ(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_comp_type (req_comp_type),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .cu_unit_id    (cu_unit_id),
        .cu_request    (cu_request),
        .cu_ready      (cu_ready),
        .cu_done       (cu_done),
        .cu_comp_type  (cu_comp_type),
        .cu_data_in    (cu_data_in),
        .cu_result     (cu_result),
        .busy          (busy),
        .timeout_cnt   (timeout_cnt)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] onehot;

        rst_n     = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        cu_ready  = 1'b0;
        cu_done   = 1'b0;
        cu_result = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[i]      = 32'hA000_0000 + 32'(i);
            req_comp_type[i] = comp_type_e'(i);
        end

        // ---- reset state ----
        step();
        step();
        req_valid = 4'b1111;
        #1;
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_req_ready",   32'(req_ready),   32'd0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst_cu_request",  32'(cu_request),  32'd0);
        chk("rst_cu_unit_id",  32'(cu_unit_id),  32'd0);
        chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        chk("rst_rsp_err",     32'(rsp_err),     32'd0);
        chk("rst_rsp_data",    rsp_data,         32'd0);
        req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        step();

        // ---- all four requesting: grant order 0,1,2,3 ----
        for (int k = 0; k < 4; k++) begin
            onehot    = 4'b0001 << k;
            req_valid = 4'b1111;
            cu_ready  = 1'b1;
            #1;
            chk("rr_grant", 32'(req_ready), 32'(onehot));
            step();                                   // cycle 1: ISSUE
            chk("rr_cu_request", 32'(cu_request),   32'd1);
            chk("rr_unit_id",    32'(cu_unit_id),   32'(k));
            chk("rr_data_in",    cu_data_in,        32'hA000_0000 + 32'(k));
            chk("rr_comp_type",  32'(cu_comp_type), 32'(k));
            step();                                   // cycle 2: WAIT
            chk("rr_req_drop", 32'(cu_request), 32'd0);
            step();                                   // cycle 3: WAIT
            step();                                   // cycle 4: WAIT, done
            cu_done   = 1'b1;
            cu_result = 32'h1000_0000 + 32'(k);
            step();                                   // cycle 5: RESP
            cu_done = 1'b0;
            #1;
            chk("rr_rsp_valid",  32'(rsp_valid), 32'(onehot));
            chk("rr_rsp_data",   rsp_data,       32'h1000_0000 + 32'(k));
            chk("rr_rsp_err",    32'(rsp_err),   32'd0);
            chk("rr_no_regrant", 32'(req_ready), 32'd0);
            rsp_ready = onehot;
            step();
            rsp_ready = 4'b0000;
            $display("job %0d: unit_id=%0d result=%h", k, k, rsp_data);
        end

        // ---- single requester 2 with cu_ready held low for 5 cycles ----
        req_valid = 4'b0100;
        cu_ready  = 1'b0;
        #1;
        chk("stall_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_cu_request", 32'(cu_request),   32'd1);
            chk("stall_unit_id",    32'(cu_unit_id),   32'd2);
            chk("stall_data_in",    cu_data_in,        32'hA000_0002);
            chk("stall_comp_type",  32'(cu_comp_type), 32'd2);
            step();
        end
        cu_ready = 1'b1;
        #1;
        chk("stall_cu_request6", 32'(cu_request), 32'd1);
        step();
        cu_ready = 1'b0;
        #1;
        chk("stall_req_drop", 32'(cu_request), 32'd0);
        cu_done   = 1'b1;
        cu_result = 32'h5555_0002;
        step();
        cu_done = 1'b0;
        $display("job stall: unit_id=2 result=%h", rsp_data);

        // ---- rsp_ready withheld 10 cycles; other requesters' rsp_ready ignored ----
        rsp_ready = 4'b1011;
        req_valid = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'b0100);
            chk("hold_rsp_data",  rsp_data,       32'h5555_0002);
            chk("hold_no_grant",  32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 4'b0100;
        step();
        rsp_ready = 4'b0000;
        #1;
        chk("hold_idle",      32'(busy),      32'd0);
        chk("hold_next_grant", 32'(req_ready), 32'b0001);

        // ---- timeout: requester 0, cu_done never arrives ----
        step();                                       // ISSUE
        req_valid = 4'b0000;
        cu_ready  = 1'b1;
        #1;
        chk("to_unit_id", 32'(cu_unit_id), 32'd0);
        step();                                       // WAIT entry
        cu_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("to_no_rsp", 32'(rsp_valid), 32'd0);
            step();
        end
        chk("to_rsp_valid",   32'(rsp_valid),   32'b0001);
        chk("to_rsp_err",     32'(rsp_err),     32'd1);
        chk("to_timeout_cnt", 32'(timeout_cnt), 32'd1);
        chk("to_rsp_data",    rsp_data,         32'h5555_0002);
        // cu_done arriving outside WAIT must not disturb the held response
        cu_done   = 1'b1;
        cu_result = 32'h0000_0BAD;
        step();
        cu_done = 1'b0;
        #1;
        chk("late_done_data", rsp_data,       32'h5555_0002);
        chk("late_done_err",  32'(rsp_err),   32'd1);
        rsp_ready = 4'b0001;
        step();
        rsp_ready = 4'b0000;
        $display("job timeout: unit_id=0 err=1 timeout_cnt=%0d", timeout_cnt);

        // ---- cu_done on the timeout cycle wins: requester 1 ----
        req_valid = 4'b0010;
        #1;
        chk("race_grant", 32'(req_ready), 32'b0010);
        step();                                       // ISSUE
        req_valid = 4'b0000;
        cu_ready  = 1'b1;
        step();                                       // WAIT entry
        cu_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
        end
        cu_done   = 1'b1;                             // last counted cycle
        cu_result = 32'hDEAD_BEEF;
        step();
        cu_done = 1'b0;
        #1;
        chk("race_rsp_valid",   32'(rsp_valid),   32'b0010);
        chk("race_rsp_err",     32'(rsp_err),     32'd0);
        chk("race_rsp_data",    rsp_data,         32'hDEAD_BEEF);
        chk("race_timeout_cnt", 32'(timeout_cnt), 32'd1);
        rsp_ready = 4'b0010;
        step();
        rsp_ready = 4'b0000;
        $display("job race: unit_id=1 result=%h", rsp_data);

        // ---- reset during WAIT, then a late cu_done ----
        req_valid = 4'b1000;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b1000);
        step();                                       // ISSUE
        req_valid = 4'b0000;
        cu_ready  = 1'b1;
        step();                                       // WAIT
        cu_ready = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        cu_done   = 1'b1;
        cu_result = 32'h0000_1234;
        #1;
        chk("mid_rst_busy",     32'(busy),        32'd0);
        chk("mid_rst_rsp",      32'(rsp_valid),   32'd0);
        chk("mid_rst_tcnt",     32'(timeout_cnt), 32'd0);
        chk("mid_rst_unit_id",  32'(cu_unit_id),  32'd0);
        chk("mid_rst_rsp_data", rsp_data,         32'd0);
        step();
        cu_done = 1'b0;
        #1;
        chk("mid_late_rsp",  32'(rsp_valid), 32'd0);
        chk("mid_late_busy", 32'(busy),      32'd0);
        req_valid = 4'b1111;
        #1;
        chk("mid_first_prio", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        #1;
        chk("mid_issue_id", 32'(cu_unit_id), 32'd0);
        $display("job after reset: granted unit_id=%0d", cu_unit_id);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cu_arbiter.md
CU_ARBITER -- requirements
Module: cu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024: max cycles in WAIT before timeout abort.
REQ-002 SHALL have parameter N_REQ, fixed 4: number of requesters, matching the 2-bit unit_id.
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 4: per-requester job request.
REQ-006 SHALL have port req_ready, output, 4: one-hot job accept pulse.
REQ-007 SHALL have port req_comp_type, input, 4 x comp_type_e (accel_pkg): per-requester operation.
REQ-008 SHALL have port req_data, input, 4 x data_t (accel_pkg): per-requester operand vector.
REQ-009 SHALL have port rsp_valid, output, 4: one-hot, result available for that requester.
REQ-010 SHALL have port rsp_ready, input, 4: requester consumes the result.
REQ-011 SHALL have port rsp_data, output, data_t: result payload.
REQ-012 SHALL have port rsp_err, output, 1: qualifies rsp_valid; 1 = timeout abort, rsp_data invalid.
REQ-013 SHALL have port cu_unit_id, output, 2: to the shared compute unit's unit_id.
REQ-014 SHALL have port cu_request, output, 1: to the shared compute unit's request.
REQ-015 SHALL have port cu_ready, input, 1: from the shared compute unit's ready.
REQ-016 SHALL have port cu_done, input, 1: from the shared compute unit's done.
REQ-017 SHALL have port cu_comp_type, output, comp_type_e: to the shared compute unit's comp_type.
REQ-018 SHALL have port cu_data_in, output, data_t: to the shared compute unit's data_in.
REQ-019 SHALL have port cu_result, input, data_t: from the shared compute unit's result.
REQ-020 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-021 SHALL have port timeout_cnt, output, 16: saturating count of timeout aborts.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one job in flight at a time.
REQ-023 IDLE: when any req_valid is high, SHALL select the winner round-robin, searching from last_grant+1 mod 4 upward.
REQ-024 IDLE grant: in the same cycle SHALL assert req_ready[winner], latch id, comp_type and data, and go to ISSUE.
REQ-025 IDLE with no req_valid: SHALL stay in IDLE.
REQ-026 req_ready SHALL only be asserted in IDLE, for exactly one cycle per accepted job.
REQ-027 ISSUE: SHALL hold cu_request=1, with cu_unit_id, cu_comp_type and cu_data_in driven from the latches.
REQ-028 ISSUE: SHALL go to WAIT on the first cycle where cu_request and cu_ready are both 1; the request drops the next cycle.
REQ-029 Outside ISSUE, cu_request SHALL be 0; cu_* payload outputs SHALL hold the latched values.
REQ-030 WAIT: wait counter SHALL clear on entry and increment each cycle.
REQ-031 WAIT: on cu_done=1, SHALL register cu_result into rsp_data, set rsp_err=0, and go to RESP.
REQ-032 WAIT: if the counter reaches TIMEOUT_CYC-1 without cu_done, SHALL set rsp_err=1, leave rsp_data unchanged, increment timeout_cnt (saturating at 0xFFFF), and go to RESP.
REQ-033 WAIT: cu_done arriving on the timeout cycle SHALL win (normal completion, no timeout).
REQ-034 cu_done outside WAIT SHALL be ignored.
REQ-035 RESP: SHALL hold rsp_valid[id]=1, rsp_data and rsp_err stable until rsp_ready[id]=1.
REQ-036 RESP completion: SHALL then set last_grant=id and go to IDLE; rsp_ready from other requesters SHALL be ignored.
REQ-037 Minimum latency SHALL be: grant at cycle 0, cu_request at cycle 1, and rsp_valid one cycle after cu_done is sampled.
REQ-038 A requester holding req_valid during its own RESP SHALL NOT be re-granted before IDLE.
REQ-039 Round-robin SHALL guarantee each continuously requesting requester a grant within 4 jobs.

Reset
REQ-040 rst_n=0 sampled at a clk edge SHALL force state=IDLE and last_grant=3, so requester 0 has first priority.
REQ-041 Reset SHALL zero req_ready, rsp_valid, rsp_err, cu_request, cu_unit_id, timeout_cnt, the wait counter, the latches and rsp_data.
REQ-042 Reset mid-job (any state) SHALL abandon the job with no rsp_valid; a late cu_done is ignored.
REQ-043 Reset SHALL NOT act asynchronously: outputs change only at a clk edge.

Verification
REQ-044 All req_valid=4'b1111 held for 4 jobs, cu_ready=1, cu_done 3 cycles after request -> grant order 0,1,2,3; rsp_valid one-hot in the same order.
REQ-045 req_valid=4'b0100 with cu_ready low for 5 cycles -> cu_request high for 6 cycles, cu_unit_id=2, payload stable throughout.
REQ-046 TIMEOUT_CYC=8, cu_done never asserted -> rsp_valid[id]=1 with rsp_err=1 exactly 8 cycles after WAIT entry; timeout_cnt=1.
REQ-047 cu_done asserted on the timeout cycle -> rsp_err=0 and rsp_data=cu_result.
REQ-048 rsp_ready withheld for 10 cycles -> rsp_valid and rsp_data held; no new req_ready; IDLE the cycle after rsp_ready.
REQ-049 rst_n=0 during WAIT, followed by cu_done -> no rsp_valid, busy=0, next grant goes to requester 0.
